// File: rtl/ss_mac_param_pkg.sv
// Shared definitions for the stochastic MAC: FSM state encoding and default sizing.
package ss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_N_CH     = 8;
    localparam int DEF_DW       = 8;
    localparam int DEF_LEN_LOG2 = 8;

endpackage

// File: rtl/ss_mac_param_if.sv
// Control/data bundle between a stream requester and the stochastic MAC.
interface ss_mac_param_if
    import ss_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int DW       = DEF_DW,
    parameter int LEN_LOG2 = DEF_LEN_LOG2
) ();

    localparam int SEL_W = $clog2(N_CH);

    logic                 start;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [N_CH*DW-1:0]   x_input;
    logic [N_CH*DW-1:0]   x_randnum;
    logic                 busy;
    logic                 done;
    logic [LEN_LOG2:0]    z_output;

    modport master (
        output start, mode, sel, x_input, x_randnum,
        input  busy, done, z_output
    );

    modport slave (
        input  start, mode, sel, x_input, x_randnum,
        output busy, done, z_output
    );

endinterface

// File: rtl/ss_mac_param_generator.sv
// Stochastic bit generator: emits 1 when the random draw falls below the magnitude.
module ss_generator #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] r,
    output logic          bit_out
);

    assign bit_out = (r < x);

endmodule

// File: rtl/ss_mac_param.sv
// Stochastic MAC: counts 1-bits of one selected (or round-robin) channel over 2^LEN_LOG2 cycles.
module ss_mac_param
    import ss_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int DW       = DEF_DW,
    parameter int LEN_LOG2 = DEF_LEN_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    ss_mac_param_if.slave    bus
);

    localparam int SEL_W = $clog2(N_CH);
    localparam logic [LEN_LOG2-1:0] CNT_LAST = '1;
    localparam logic [SEL_W-1:0]    CH_LAST  = SEL_W'(N_CH - 1);

    state_t              state_reg, state_next;
    logic [LEN_LOG2:0]   z_reg, z_next;
    logic [LEN_LOG2-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0]    ptr_reg, ptr_next;
    logic                mode_reg, mode_next;
    logic [SEL_W-1:0]    sel_reg, sel_next;

    logic [N_CH-1:0]     stoch_bits;
    logic [SEL_W-1:0]    sel_clamped;
    logic [SEL_W-1:0]    chan_idx;
    logic                chan_bit;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        ss_generator #(.DW(DW)) u_gen (
            .x       (bus.x_input[gi*DW +: DW]),
            .r       (bus.x_randnum[gi*DW +: DW]),
            .bit_out (stoch_bits[gi])
        );
    end

    // Out-of-range fixed selections fold onto the last channel.
    assign sel_clamped = (int'(sel_reg) >= N_CH) ? CH_LAST : sel_reg;
    assign chan_idx    = mode_reg ? ptr_reg : sel_clamped;
    assign chan_bit    = stoch_bits[chan_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            z_reg     <= '0;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            mode_reg  <= 1'b0;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            z_reg     <= z_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            mode_reg  <= mode_next;
            sel_reg   <= sel_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        z_next     = z_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        mode_next  = mode_reg;
        sel_next   = sel_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                    z_next     = '0;
                    cnt_next   = '0;
                    ptr_next   = '0;
                    mode_next  = bus.mode;
                    sel_next   = bus.sel;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here: a run cannot be restarted.
                z_next   = z_reg + (LEN_LOG2+1)'(chan_bit);
                cnt_next = cnt_reg + 1'b1;
                ptr_next = (ptr_reg == CH_LAST) ? '0 : ptr_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.busy     = (state_reg == ST_RUN);
    assign bus.done     = (state_reg == ST_DONE);
    assign bus.z_output = z_reg;

endmodule

// File: doc/ss_mac_param.md
SS_MAC_PARAM -- requirements
Module: ss_mac_param

Interface
REQ-001 Parameter N_CH, default 8, number of input channels (2..64).
REQ-002 Parameter DW, default 8, magnitude width of inputs and random numbers.
REQ-003 Parameter LEN_LOG2, default 8, stream length L = 2^LEN_LOG2 cycles.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to begin one stream accumulation.
REQ-007 mode  input  1  0 = fixed channel from sel; 1 = round-robin over all channels.
REQ-008 sel  input  clog2(N_CH)  fixed channel index, used when mode=0.
REQ-009 x_input  input  N_CH*DW  packed channel magnitudes; channel k at bits [k*DW +: DW].
REQ-010 x_randnum  input  N_CH*DW  packed per-channel random numbers, same packing, new value each cycle.
REQ-011 busy  output  1  high while accumulating.
REQ-012 done  output  1  high while a completed result is held.
REQ-013 z_output  output  LEN_LOG2+1  accumulated count of 1-bits.

Function
REQ-014 Per-channel stochastic bit SHALL be 1 exactly when x_randnum[k] < x_input[k] (unsigned), combinational.
REQ-015 FSM SHALL have states IDLE, RUN and DONE; the reset state is IDLE.
REQ-016 IDLE or DONE with start=1 SHALL go to RUN on that edge, clear z_output to 0, clear the cycle counter and latch mode and sel.
REQ-017 In RUN, each edge SHALL add the selected channel bit to z_output and increment the cycle counter.
REQ-018 mode=0 SHALL select the channel at the latched sel; sel >= N_CH SHALL select channel N_CH-1.
REQ-019 mode=1 SHALL start at channel 0 and advance the channel pointer by one each RUN cycle, wrapping from N_CH-1 to 0 for any N_CH.
REQ-020 After exactly L RUN edges the FSM SHALL enter DONE; done rises L cycles after the start edge.
REQ-021 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-022 start during RUN SHALL be ignored with no restart and no counter change.
REQ-023 In DONE, z_output SHALL hold until the next accepted start or reset.
REQ-024 z_output width LEN_LOG2+1 SHALL hold the maximum value L without overflow; no saturation logic is needed.
REQ-025 In IDLE, z_output SHALL hold its value (0 after reset).

Reset
REQ-026 rst low SHALL immediately force state IDLE, z_output 0, counter 0, channel pointer 0, latched mode/sel 0, busy 0 and done 0, including mid-RUN.
REQ-027 After rst releases, no accumulation SHALL occur until a new start is accepted.

Structure
REQ-028 A shared package ss_pkg SHALL hold the FSM state encoding and default parameter constants (DW=8, LEN_LOG2=8, N_CH=8).
REQ-029 The comparator SHALL be a sub-module ss_generator (parameter DW), instantiated N_CH times via generate.
REQ-030 Channel mux, FSM, counter and accumulator SHALL reside in ss_mac_param.

Verification (N_CH=8, DW=8, LEN_LOG2=8; randnum on all channels ramps 0..255, one step per RUN cycle)
REQ-031 mode=0, sel=3, x_input ch3=128, start pulse -> busy for 256 cycles, then done=1 and z_output=128.
REQ-032 mode=0, sel=0, ch0=0 -> z_output=0; rerun with ch0=255 -> z_output=255; third run with randnum held at 0 and ch0=255 -> z_output=256.
REQ-033 mode=1, all channels x=64 -> z_output=64; mode=1 with channels 0..7 set to 0,255,0,255,... -> pointer visits each channel 32 times, result checked against a reference model.
REQ-034 rst low at RUN cycle 100 -> z_output=0, busy=0, done=0 at once; after release there is no activity until start.
REQ-035 start re-pulsed at RUN cycle 50 -> ignored, done still at cycle 256; start while in DONE -> z_output clears to 0 and a new RUN begins next cycle.
